bus_rr_router: RTL
==================

# bus_rr_router

- Synthesizable shared-bus router that sits directly downstream of the per-driver input FIFOs filled by `Driver_Monitor`.
- Samples each FIFO's pending flag and grants one source at a time by round-robin. It pops the head packet and delivers it to the destination's output port, or to every other port on broadcast.
- It is the DUT the `Driver_Monitor` agents exercise. Its ports mirror the FIFO-side signals those agents emulate.

## Interface
Parameters:
- `drvrs`, 4: number of source/destination terminals (2..16).
- `pckg_sz`, 16: packet width in bits. Bits `[pckg_sz-1 -: 8]` hold the destination id; the rest is payload.
- `broadcast`, 8'hFF: id value meaning "deliver to all terminals except the source".

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `pndng`, input, `[drvrs-1:0]`: FIFO i holds at least one packet.
- `D_pop`, input, `[drvrs-1:0][pckg_sz-1:0]`: head packet of FIFO i. Valid whenever `pndng[i]` is high.
- `pop`, output, `[drvrs-1:0]`: one-cycle pulse that removes the head of FIFO i.
- `full`, input, `[drvrs-1:0]`: output terminal i cannot accept a packet.
- `push`, output, `[drvrs-1:0]`: one-cycle delivery strobe to terminal i.
- `D_push`, output, `[drvrs-1:0][pckg_sz-1:0]`: delivered packet, unmodified, on every pushed lane.
- `err_drop`, output, 1: one-cycle pulse when a popped packet is discarded.

## Operation
- FSM states: IDLE, POP, DELIVER.
- **IDLE**
  - If `pndng != 0`, pick winner `w` by round-robin. Search starts at `last_grant+1` and wraps modulo `drvrs`.
  - Latch `pkt <= D_pop[w]` and `src <= w`, set `last_grant <= w`, set `pop[w]`, go to POP.
  - If `pndng == 0`, stay in IDLE.
- **POP**
  - `pop[w]` is high for exactly this cycle.
  - Decode `id = pkt[pckg_sz-1 -: 8]`.
  - Valid unicast: `id < drvrs` and `id != src`. Target mask is the single bit `id`.
  - Broadcast: `id == broadcast`. Target mask is all ones except bit `src`.
  - Anything else is a drop: pulse `err_drop` next cycle, go to IDLE.
  - Otherwise go to DELIVER.
- **DELIVER**
  - Wait until `(full & mask) == 0`, all targets sampled in the same cycle. Broadcast is never partially delivered.
  - Then drive `push = mask` and `D_push[i] = pkt` for every i in mask for one cycle, and go to IDLE.
  - A target that stays full stalls delivery indefinitely. No timeout.
- Non-pushed lanes of `D_push` hold 0.
- `pndng` changes while in POP or DELIVER are ignored. Arbitration happens only in IDLE.

## Timing
- All outputs are registered.
- Reset values: `pop`, `push`, `D_push`, `err_drop` = 0; state = IDLE; `last_grant = drvrs-1`, so driver 0 has first priority after reset.
- Cycle-level sequence:
  - Edge k: IDLE samples `pndng`.
  - Cycle k+1: `pop[w]` is high.
  - Cycle k+2: earliest `push`, or the `err_drop` pulse.
- Peak throughput is one packet per 3 cycles.
- `full` is sampled at every edge that ends a POP or DELIVER cycle.
- Reset asserted mid-operation returns the block to IDLE on the next edge.
  - A packet already popped is lost, with no `err_drop` pulse.
  - Outputs are 0 in the following cycle.
- Simultaneous requests are served strictly in rotating order. No source waits more than `drvrs-1` grants.

## Structure
- Package `bus_rtr_pkg` holds:
  - the `ID_W = 8` localparam;
  - the default `broadcast` constant;
  - the state enum `rtr_state_e` {IDLE, POP, DELIVER};
  - the pure function `dest_mask(id, src, drvrs)`, which returns the target mask, or 0 for a drop.
- Sub-module `rr_arbiter`, parameterized by `drvrs`: combinational one-hot grant from `req` and `last_grant`. Top-level FSM, datapath and registers stay in `bus_rr_router`.

## Test plan
1. After reset, `pndng=4'b0001`, `D_pop[0]=16'h02AB`, `full=0` → `pop[0]` in cycle 1, `push=4'b0100` with `D_push[2]=16'h02AB` in cycle 2, `err_drop=0`.
2. `pndng=4'b1111` held, all packets unicast, `full=0` → grant order 0,1,2,3,0, one `pop` pulse every 3 cycles.
3. Source 1 sends `16'hFF5A`, `full=0` → a single push cycle with `push=4'b1101` and all three lanes equal to `16'hFF5A`.
4. Source 0 sends `16'h0311` while `full[3]=1` for 5 cycles → `push` stays 0 until the edge after `full[3]` falls, then `push=4'b1000` for one cycle.
5. Source 2 sends `16'h0700` (invalid id), then `16'h0200` (self-address) → each is popped once, `err_drop` pulses once per packet, and `push` stays 0.
6. `rst` asserted during DELIVER → next cycle all outputs 0; the next grant goes to driver 0 if it is pending.

Source files
------------

// File: rtl/bus_rr_router_pkg.sv
// Shared types and helpers for the round-robin bus router.
// Destination decode lives here so the router and its users agree on it.
package bus_rtr_pkg;

  localparam int ID_W = 8;
  localparam int MAX_DRVRS = 16;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DELIVER
  } rtr_state_e;

  // Zero mask means the packet is dropped.
  function automatic logic [MAX_DRVRS-1:0] dest_mask(
    input logic [ID_W-1:0] id,
    input logic [3:0]      src,
    input int              drvrs,
    input logic [ID_W-1:0] bcast = BROADCAST
  );
    logic [MAX_DRVRS-1:0] m;
    m = '0;
    if (id == bcast) begin
      for (int i = 0; i < MAX_DRVRS; i++)
        m[i] = (i < drvrs) && (i != int'(src));
    end else if ((int'(id) < drvrs) &&
                 (id != ID_W'(src))) begin
      m[id[3:0]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_rr_router_if.sv
// FIFO-side and terminal-side signals of the router.
// master = agents/FIFOs, slave = router.
interface bus_rr_router_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);

  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              full;
  logic [drvrs-1:0]              push;
  logic [drvrs-1:0][pckg_sz-1:0] D_push;
  logic                          err_drop;

  modport master (
    output pndng, D_pop, full,
    input  pop, push, D_push, err_drop
  );

  modport slave (
    input  pndng, D_pop, full,
    output pop, push, D_push, err_drop
  );

endinterface

// File: rtl/bus_rr_router_arbiter.sv
// Combinational round-robin pick.
// Search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int drvrs = 4,
  parameter int IW    = 2
) (
  input  logic [drvrs-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [drvrs-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  always_comb begin
    logic        found;
    int          j;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    idx     = '0;
    for (int i = 1; i <= drvrs; i++) begin
      j   = (int'(last_grant) + i) % drvrs;
      idx = j[IW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_router.sv
// Shared-bus router: round-robin pop from source FIFOs,
// unicast or broadcast delivery to output terminals.
module bus_rr_router
  import bus_rtr_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input logic            clk,
  input logic            rst,
  bus_rr_router_if.slave bus
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  rtr_state_e state_q, state_d;

  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      src_q, src_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0]   mask_q, mask_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;
  logic               err_q, err_d;

  logic [drvrs-1:0][pckg_sz-1:0] dpush_q, dpush_d;

  logic [drvrs-1:0]     gnt;
  logic [IW-1:0]        gnt_idx;
  logic [MAX_DRVRS-1:0] mask_raw;
  logic [drvrs-1:0]     mask_now;
  logic                 mask_unused;

  rr_arbiter #(
    .drvrs(drvrs),
    .IW   (IW)
  ) u_arb (
    .req       (bus.pndng),
    .last_grant(last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  assign mask_raw = dest_mask(
    pkt_q[pckg_sz-1 -: ID_W], 4'(src_q),
    drvrs, broadcast);
  assign mask_now    = mask_raw[drvrs-1:0];
  assign mask_unused = ^mask_raw;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bus.pndng) state_d = POP;
      POP:     state_d = (mask_now == '0) ? IDLE : DELIVER;
      DELIVER: if (|push_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Push in DELIVER only once; push_q marks the delivery cycle.
  always_comb begin
    pkt_d   = pkt_q;
    src_d   = src_q;
    last_d  = last_q;
    mask_d  = mask_q;
    pop_d   = '0;
    push_d  = '0;
    err_d   = 1'b0;
    dpush_d = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.pndng) begin
          pkt_d  = bus.D_pop[gnt_idx];
          src_d  = gnt_idx;
          last_d = gnt_idx;
          pop_d  = gnt;
        end
      end
      POP: begin
        mask_d = mask_now;
        if (mask_now == '0)
          err_d = 1'b1;
        else if ((bus.full & mask_now) == '0)
          push_d = mask_now;
      end
      DELIVER: begin
        if (push_q == '0 &&
            (bus.full & mask_q) == '0)
          push_d = mask_q;
      end
      default: ;
    endcase
    for (int i = 0; i < drvrs; i++)
      if (push_d[i]) dpush_d[i] = pkt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IW'(drvrs - 1);
      src_q   <= '0;
      pkt_q   <= '0;
      mask_q  <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      err_q   <= 1'b0;
      dpush_q <= '0;
    end else begin
      last_q  <= last_d;
      src_q   <= src_d;
      pkt_q   <= pkt_d;
      mask_q  <= mask_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      err_q   <= err_d;
      dpush_q <= dpush_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.D_push   = dpush_q;
  assign bus.err_drop = err_q;

endmodule
